// File: rtl/brp_resolve.sv
// EX-stage branch resolution: compares the IF prediction record against the ALU outcome,
// emits update/redirect strobes, a timed flush of younger stages and accuracy counters.
package rv32i_types;
  typedef enum logic [6:0] {
    op_lui   = 7'b0110111,
    op_auipc = 7'b0010111,
    op_jal   = 7'b1101111,
    op_jalr  = 7'b1100111,
    op_br    = 7'b1100011,
    op_load  = 7'b0000011,
    op_store = 7'b0100011,
    op_imm   = 7'b0010011,
    op_reg   = 7'b0110011,
    op_csr   = 7'b1110011
  } rv32i_opcode;

  typedef struct packed {
    logic        predicted;
    logic        prediction;
    logic        mp_valid;
    logic        mispredicted;
    logic [31:0] brp_alt;
  } rv32i_brp_word;
endpackage

module brp_resolve
  import rv32i_types::*;
#(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic              stall,
  input  logic [31:0]       pc_ex,
  input  rv32i_opcode       opcode_ex,
  input  logic              br_en,
  input  logic [31:0]       alu_target,
  input  rv32i_brp_word     brp_ex,
  output rv32i_brp_word     brp_mem,
  output logic              update,
  output logic              redirect,
  output logic [31:0]       redirect_pc,
  output logic              flush,
  output logic [CNT_W-1:0]  c_total,
  output logic [CNT_W-1:0]  c_correct
);

  typedef enum logic [0:0] {S_IDLE, S_FLUSH} state_t;

  state_t             state_q;
  logic [3:0]         cnt_q;
  rv32i_brp_word      brp_mem_q;
  logic               update_q, redirect_q;
  logic [31:0]        redirect_pc_q;
  logic [CNT_W-1:0]   c_total_q, c_correct_q;

  logic               resolve;
  rv32i_brp_word      rec_d;
  logic               upd_d, redir_d, mis_d;
  logic [31:0]        target_d;

  // Fetch already fell through to pc_ex+4, so the PC itself is not needed to resolve.
  logic pc_unused;
  assign pc_unused = ^pc_ex;

  assign resolve = ex_valid & ~stall & (state_q == S_IDLE);

  // NOTE: every signal gets a default before the case so no latch is inferred.
  always_comb begin
    rec_d    = '0;
    upd_d    = 1'b0;
    redir_d  = 1'b0;
    mis_d    = 1'b0;
    target_d = alu_target;
    case (opcode_ex)
      op_br: begin
        rec_d          = brp_ex;
        rec_d.mp_valid = brp_ex.predicted;
        if (brp_ex.predicted) begin
          mis_d              = (brp_ex.prediction != br_en);
          rec_d.mispredicted = mis_d;
          upd_d              = 1'b1;
          redir_d            = mis_d;
          target_d           = brp_ex.brp_alt;
        end else begin
          redir_d = br_en;
        end
      end
      op_jal: begin
        rec_d          = brp_ex;
        rec_d.mp_valid = 1'b0;
      end
      op_jalr: begin
        rec_d          = brp_ex;
        rec_d.mp_valid = 1'b0;
        redir_d        = 1'b1;
        target_d       = {alu_target[31:1], 1'b0};
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only; reset is synchronous.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      brp_mem_q     <= '0;
      update_q      <= 1'b0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
      c_total_q     <= '0;
      c_correct_q   <= '0;
    end else begin
      update_q   <= resolve & upd_d;
      redirect_q <= resolve & redir_d;
      if (resolve & redir_d) redirect_pc_q <= target_d;
      if (!stall) brp_mem_q <= resolve ? rec_d : '0;

      case (state_q)
        S_IDLE: begin
          if (resolve & redir_d) begin
            state_q <= S_FLUSH;
            cnt_q   <= 4'(FLUSH_CYCLES - 1);
          end
        end
        S_FLUSH: begin
          if (!stall) begin
            if (cnt_q == 4'd0) state_q <= S_IDLE;
            else               cnt_q   <= cnt_q - 4'd1;
          end
        end
        default: state_q <= S_IDLE;
      endcase

      // Saturating counters; c_total always saturates no later than c_correct.
      if (resolve & upd_d) begin
        if (c_total_q != '1) c_total_q <= c_total_q + CNT_W'(1);
        if (!mis_d && (c_correct_q != '1)) c_correct_q <= c_correct_q + CNT_W'(1);
      end
    end
  end

  assign brp_mem     = brp_mem_q;
  assign update      = update_q;
  assign redirect    = redirect_q;
  assign redirect_pc = redirect_pc_q;
  assign flush       = (state_q == S_FLUSH);
  assign c_total     = c_total_q;
  assign c_correct   = c_correct_q;

endmodule

// File: tb/tb_brp_resolve.sv
// Scoreboard bench for brp_resolve: a transaction-level model queues expected outputs
// per cycle, and an independent monitor pops and compares them against the DUT.
module tb_brp_resolve;
  import rv32i_types::*;

  localparam int FC  = 2;
  localparam int CW  = 4;
  localparam int MAX = (1 << CW) - 1;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            ex_valid = 1'b0;
  logic            stall = 1'b0;
  logic [31:0]     pc_ex = '0;
  rv32i_opcode     opcode_ex = op_imm;
  logic            br_en = 1'b0;
  logic [31:0]     alu_target = '0;
  rv32i_brp_word   brp_ex = '0;
  rv32i_brp_word   brp_mem;
  logic            update, redirect, flush;
  logic [31:0]     redirect_pc;
  logic [CW-1:0]   c_total, c_correct;

  brp_resolve #(.FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .stall(stall), .pc_ex(pc_ex),
    .opcode_ex(opcode_ex), .br_en(br_en), .alu_target(alu_target), .brp_ex(brp_ex),
    .brp_mem(brp_mem), .update(update), .redirect(redirect), .redirect_pc(redirect_pc),
    .flush(flush), .c_total(c_total), .c_correct(c_correct)
  );

  always #5 clk = ~clk;

  typedef struct {
    rv32i_brp_word brp;
    logic          upd;
    logic          redir;
    logic [31:0]   rpc;
    logic          flush;
    int            tot;
    int            cor;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_mis = 0;

  // Model state: what the outputs should look like after the next edge.
  rv32i_brp_word m_brp = '0;
  int            m_flush_left = 0;
  int            m_tot = 0, m_cor = 0;
  logic [31:0]   m_rpc = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic rv32i_brp_word mk(input logic pd, input logic pr, input logic [31:0] alt);
    rv32i_brp_word b;
    b.predicted    = pd;
    b.prediction   = pr;
    b.mp_valid     = 1'($urandom);
    b.mispredicted = 1'($urandom);
    b.brp_alt      = alt;
    return b;
  endfunction

  // Apply one cycle of inputs and queue the outputs they should produce one edge later.
  task automatic step(input logic r, input logic ev, input logic st, input rv32i_opcode op,
                      input logic be, input logic [31:0] tgt, input rv32i_brp_word b);
    exp_t          e;
    logic          res, redir, upd, hit;
    rv32i_brp_word rec;
    logic [31:0]   tpc;
    @(posedge clk);
    #2;
    rst = r; ex_valid = ev; stall = st; opcode_ex = op; br_en = be;
    alu_target = tgt; brp_ex = b; pc_ex = $urandom;
    redir = 1'b0; upd = 1'b0; hit = 1'b0; rec = '0; tpc = '0;
    if (r) begin
      m_brp = '0; m_flush_left = 0; m_tot = 0; m_cor = 0; m_rpc = '0;
    end else begin
      res = ev && !st && (m_flush_left == 0);
      if (res) begin
        if (op == op_br && b.predicted) begin
          rec = b; rec.mp_valid = 1'b1; rec.mispredicted = (b.prediction != be);
          upd = 1'b1; hit = (b.prediction == be);
          if (!hit) begin redir = 1'b1; tpc = b.brp_alt; end
        end else if (op == op_br) begin
          rec = b; rec.mp_valid = 1'b0;
          if (be) begin redir = 1'b1; tpc = tgt; end
        end else if (op == op_jal) begin
          rec = b; rec.mp_valid = 1'b0;
        end else if (op == op_jalr) begin
          rec = b; rec.mp_valid = 1'b0; redir = 1'b1; tpc = tgt & ~32'h1;
        end
      end
      if (m_flush_left > 0 && !st) m_flush_left--;
      if (redir) begin m_flush_left = FC; m_rpc = tpc; end
      if (!st) m_brp = rec;
      if (upd) begin
        if (m_tot < MAX) m_tot++;
        if (hit && m_cor < MAX) m_cor++;
      end
    end
    e.brp = m_brp; e.upd = upd; e.redir = redir; e.rpc = m_rpc;
    e.flush = (m_flush_left > 0); e.tot = m_tot; e.cor = m_cor;
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, op_imm, 1'b0, 32'h0, '0);
  endtask

  // Monitor: registered outputs are compared one time unit after every edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        check("brp_mem",   64'(brp_mem),   64'(e.brp));
        check("update",    64'(update),    64'(e.upd));
        check("redirect",  64'(redirect),  64'(e.redir));
        if (e.redir) check("redirect_pc", 64'(redirect_pc), 64'(e.rpc));
        check("flush",     64'(flush),     64'(e.flush));
        check("c_total",   64'(c_total),   64'(e.tot));
        check("c_correct", 64'(c_correct), 64'(e.cor));
      end
    end
  end

  initial begin
    rv32i_opcode ops[6] = '{op_br, op_br, op_br, op_jal, op_jalr, op_imm};
    rv32i_brp_word b;

    step(1'b1, 1'b0, 1'b0, op_imm, 1'b0, 32'h0, '0);
    step(1'b1, 1'b1, 1'b0, op_br, 1'b1, 32'h0, mk(1'b1, 1'b1, 32'h300));
    idle(1);

    // Correct prediction, then a mispredict followed by branches squashed in the flush window.
    step(1'b0, 1'b1, 1'b0, op_br, 1'b1, 32'h0, mk(1'b1, 1'b1, 32'h200));
    step(1'b0, 1'b1, 1'b0, op_br, 1'b0, 32'h0, mk(1'b1, 1'b1, 32'h104));
    step(1'b0, 1'b1, 1'b0, op_br, 1'b0, 32'h0, mk(1'b1, 1'b1, 32'h500));
    step(1'b0, 1'b1, 1'b0, op_br, 1'b1, 32'h0, mk(1'b1, 1'b0, 32'h600));
    idle(2);

    // JALR clears bit 0 of the target.
    step(1'b0, 1'b1, 1'b0, op_jalr, 1'b0, 32'h2001, mk(1'b0, 1'b0, 32'h0));
    idle(3);

    // Mispredict held by a 3-cycle stall, then a 3-cycle stall inside the flush window.
    b = mk(1'b1, 1'b0, 32'h804);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, op_br, 1'b1, 32'h0, b);
    step(1'b0, 1'b1, 1'b0, op_br, 1'b1, 32'h0, b);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, op_imm, 1'b0, 32'h0, '0);
    idle(4);

    // Reset in the middle of a flush.
    step(1'b0, 1'b1, 1'b0, op_br, 1'b1, 32'h0, mk(1'b1, 1'b0, 32'h904));
    step(1'b1, 1'b0, 1'b0, op_imm, 1'b0, 32'h0, '0);
    idle(2);

    // 17 correct predictions saturate both 4-bit counters at 15.
    for (int i = 0; i < 17; i++) step(1'b0, 1'b1, 1'b0, op_br, 1'b0, 32'h0, mk(1'b1, 1'b0, 32'h40));
    step(1'b0, 1'b1, 1'b0, op_br, 1'b1, 32'h0, mk(1'b1, 1'b0, 32'h44));
    idle(3);

    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 4) == 0), ops[$urandom_range(0, 5)], 1'($urandom),
           $urandom, mk(1'($urandom), 1'($urandom), $urandom));
    end
    idle(2);

    for (int i = 0; i < 8 && q.size() > 0; i++) @(posedge clk);
    #3;
    if (q.size() != 0) begin
      n_mis++;
      $display("FAIL drain: %0d expected cycles never compared", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

// File: doc/brp_resolve.md
# brp_resolve

EX-stage branch resolution unit, directly downstream of the IF-stage predictor. It takes the prediction record carried down the pipeline with each instruction and compares it against the ALU's actual branch outcome. It then produces the resolved record, the predictor-update pulse, the fetch redirect and a timed flush of younger stages. It also keeps the prediction-accuracy counters.

## Interface
Parameters:
- FLUSH_CYCLES, 2: cycles `flush` stays high after a redirect (younger stages squashed); legal range 1..15.
- CNT_W, 32: width of the accuracy counters.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- ex_valid  in  1  a live instruction occupies EX this cycle.
- stall  in  1  pipeline stall; EX contents held.
- pc_ex  in  32  PC of the EX instruction.
- opcode_ex  in  rv32i_opcode  opcode of the EX instruction.
- br_en  in  1  ALU compare result, 1 = taken.
- alu_target  in  32  ALU-computed target, used for JALR and unpredicted branches.
- brp_ex  in  rv32i_brp_word  prediction record from IF.
- brp_mem  out  rv32i_brp_word  resolved record to MEM; also fed back to the predictor.
- update  out  1  one-cycle predictor-table update strobe.
- redirect  out  1  one-cycle fetch redirect strobe.
- redirect_pc  out  32  correct next PC; valid when `redirect` is 1.
- flush  out  1  squash IF/ID/EX-input contents.
- c_total  out  CNT_W  number of predicted branches resolved.
- c_correct  out  CNT_W  number of those that were correctly predicted.

## Operation
- **Resolve condition:** a resolve occurs when `ex_valid & !stall & !flush`. All other cycles are idle, and EX inputs are ignored.
- **op_br with brp_ex.predicted = 1:**
  - `mispredicted = (brp_ex.prediction != br_en)`.
  - Record gets `mp_valid = 1`; the other fields are copied from `brp_ex`.
  - `update` pulses.
  - On a mispredict, redirect to `brp_ex.brp_alt`.
- **op_br with predicted = 0:** fetch went to pc_ex+4.
  - If `br_en`, redirect to `alu_target`.
  - No update, no count; `mp_valid = 0`.
- **op_jal:** already steered by the predictor. No redirect, no update; record passed through with `mp_valid = 0`.
- **op_jalr:** always redirect to `{alu_target[31:1],1'b0}`. No update, no count.
- **Other opcodes:** `brp_mem = '0`, no action.
- **FSM:**
  - IDLE:
    - A resolve requiring redirect → FLUSH, with `cnt = FLUSH_CYCLES-1`.
    - Otherwise stay in IDLE.
  - FLUSH:
    - `flush = 1`.
    - If `!stall`: when `cnt == 0` → IDLE, else `cnt--`.
    - If `stall`: `cnt` holds.
- **Counters:**
  - Every predicted-branch resolve increments `c_total`; if not mispredicted, it also increments `c_correct`.
  - Both counters saturate at 2^CNT_W-1 independently; `c_correct <= c_total` always holds.

## Timing
- **Resolve latency:** a resolve in cycle N drives `brp_mem`, `update`, `redirect` and `redirect_pc` from registers in cycle N+1.
- **Strobes:** `update` and `redirect` are high exactly one cycle.
- **Flush window:** `flush` rises in cycle N+1, coincident with `redirect`, and stays high for FLUSH_CYCLES non-stalled cycles.
- **brp_mem:**
  - Reloads every non-stalled cycle.
  - Is `'0` in cycles with no resolve and while `flush` is high.
  - Holds its value while `stall` is high.
- **Counters:** update at the edge ending cycle N and are visible in N+1.
- **Branch in EX during a flush:** it is a squashed younger instruction and produces nothing.
- **Stall on a resolve cycle:** no resolve occurs; the resolve happens on the first cycle with `stall = 0`.
- **Reset:**
  - All outputs are 0 in the cycle after the rst edge: `brp_mem = '0`, strobes 0, `redirect_pc = 0`, `flush = 0`, counters 0, state IDLE.
  - `rst` asserted mid-flush returns the FSM to IDLE at the next edge; no redirect or update is emitted.

## Test plan
- **Correct prediction:** op_br, predicted = 1, prediction = 1, br_en = 1, pc_ex = 0x100 → N+1: update = 1, redirect = 0, brp_mem.mp_valid = 1, mispredicted = 0, c_total = 1, c_correct = 1.
- **Mispredict:** op_br, prediction = 1, br_en = 0, brp_alt = 0x104 → N+1: redirect = 1, redirect_pc = 0x104, update = 1, mispredicted = 1.
  - `flush` is high for N+1..N+2 (FLUSH_CYCLES = 2).
  - c_correct is unchanged.
- **JALR:** op_jalr, alu_target = 0x2001 → redirect_pc = 0x2000, update = 0, counters unchanged.
- **Branch during flush:** a second op_br presented during the flush window → no update, no redirect, counters unchanged.
- **Stall:**
  - Stall for 3 cycles on a mispredicting branch → resolve occurs only after stall drops.
  - Stall during FLUSH extends `flush` by 3 cycles.
- **Reset and saturation:**
  - rst during FLUSH → flush = 0 next cycle, all outputs 0.
  - With CNT_W = 4, 17 correct predictions → c_total = c_correct = 15.
